// File: rtl/oled_pkg.sv
// oled_pkg: shared 96x64 OLED geometry, RGB565 colours and marker coordinate type
package oled_pkg;
  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int OLED_PIXELS = 6144;
  localparam logic [15:0] RGB_RED = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
  } coord_t;
  function automatic logic [15:0] rgb_shr(input logic [15:0] c, input logic [2:0] s);
    return {c[15:11] >> s, c[10:5] >> s, c[4:0] >> s};
  endfunction
endpackage

// File: rtl/sprite_trail_renderer_if.sv
// sprite_trail_renderer_if: marker position in, OLED pixel lookup out
interface sprite_trail_renderer_if;
  logic        enable;
  logic [6:0]  var_x;
  logic [6:0]  var_y;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data;
  logic [3:0]  trail_count;
  modport master(output enable, var_x, var_y, frame_begin, pixel_index, input pixel_data, trail_count);
  modport slave(input enable, var_x, var_y, frame_begin, pixel_index, output pixel_data, trail_count);
endinterface

// File: rtl/trail_buffer.sv
// trail_buffer: circular DEPTH-entry position history, dout[0] is the newest entry
module trail_buffer import oled_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   push,
  input  coord_t din,
  output coord_t dout [DEPTH],
  output logic [3:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] D = 4'(DEPTH);
  coord_t r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [3:0] r_count;
  // write at the pointer, wrap it mod DEPTH, saturate the count once full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clr) begin
      r_wp <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_wp] <= din;
      r_wp <= r_wp == AW'(DEPTH - 1) ? '0 : r_wp + 1'b1;
      r_count <= r_count == D ? D : r_count + 4'd1;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    logic [AW:0] w_sum;
    assign w_sum = {1'b0, r_wp} + (AW+1)'(DEPTH - 1 - g);
    assign dout[g] = r_mem[w_sum >= (AW+1)'(DEPTH) ? AW'(w_sum - (AW+1)'(DEPTH)) : AW'(w_sum)];
  end
  assign count = r_count;
endmodule

// File: rtl/sprite_trail_renderer.sv
// sprite_trail_renderer: renders marker head and trail squares as RGB565; TRAIL_FADE_EN halves trail colour per age
module sprite_trail_renderer import oled_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int SIZE = 5,
  parameter logic [15:0] HEAD_COLOUR = RGB_RED,
  parameter logic [15:0] TRAIL_COLOUR = RGB_GREEN,
  parameter logic [15:0] BG_COLOUR = RGB_BLACK
) (
  input logic clk,
  input logic rst,
  sprite_trail_renderer_if.slave bus
);
  coord_t w_din;
  coord_t w_dout [DEPTH];
  logic [3:0] w_count;
  logic w_push;
  logic [7:0] w_col, w_row;
  logic [DEPTH-1:0] w_hit;
  logic [15:0] w_c [DEPTH];
  logic [15:0] w_colour, r_pixel;
  assign w_din = {bus.var_x, bus.var_y};
  assign w_push = bus.frame_begin && (w_count == 4'd0 || w_din != w_dout[0]);
  trail_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .clr(!bus.enable), .push(w_push),
    .din(w_din), .dout(w_dout), .count(w_count)
  );
  assign w_col = 8'(bus.pixel_index % 13'(OLED_W));
  assign w_row = 8'(bus.pixel_index / 13'(OLED_W));
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
`ifdef TRAIL_FADE_EN
    localparam logic [15:0] C = g == 0 ? HEAD_COLOUR : rgb_shr(TRAIL_COLOUR, 3'(g - 1));
`else
    localparam logic [15:0] C = g == 0 ? HEAD_COLOUR : TRAIL_COLOUR;
`endif
    assign w_c[g] = C;
    assign w_hit[g] = 4'(g) < w_count
      && w_col >= {1'b0, w_dout[g].x} && w_col < {1'b0, w_dout[g].x} + 8'(SIZE)
      && w_row >= {1'b0, w_dout[g].y} && w_row < {1'b0, w_dout[g].y} + 8'(SIZE);
  end
  // oldest to newest so the newest hitting entry wins
  always_comb begin
    w_colour = BG_COLOUR;
    for (int i = DEPTH - 1; i >= 0; i--) if (w_hit[i]) w_colour = w_c[i];
  end
  // one-cycle registered pixel output
  always_ff @(posedge clk) begin
    if (rst) r_pixel <= '0;
    else r_pixel <= (!bus.enable || bus.pixel_index >= 13'(OLED_PIXELS)) ? BG_COLOUR : w_colour;
  end
  assign bus.pixel_data = r_pixel;
  assign bus.trail_count = w_count;
endmodule
